pio_mem_ctl: RTL

PIO_MEM_CTL -- requirements
Module: pio_mem_ctl

---
 rtl/pio_mem_ctl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/pio_mem_ctl.sv
// PIO memory controller: host request decode, single-cycle register strobes, ack-edge wait, response.
// Optional ack-wait timeout enabled by defining PIO_TIMEOUT_EN.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif
`ifndef RESET_SIG
`define RESET_SIG input logic rst_n
`endif

module pio_mem_ctl #(
    parameter int NUM_MEM        = 4,
    parameter int SEL_LSB        = 12,
    parameter int CLK_DIV_RATIO  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    `RESET_SIG,
    input  logic                          host_req,
    input  logic                          host_wr,
    input  logic [`PIO_NBITS-1:0]         host_addr,
    input  logic [`PIO_NBITS-1:0]         host_wdata,
    output logic                          host_busy,
    output logic                          host_ack,
    output logic [`PIO_NBITS-1:0]         host_rdata,
    output logic                          host_err,
    output logic                          clk_div,
    output logic [`PIO_NBITS-1:0]         reg_addr,
    output logic [`PIO_NBITS-1:0]         reg_din,
    output logic                          reg_rd,
    output logic                          reg_wr,
    output logic [NUM_MEM-1:0]            reg_ms,
    input  logic [NUM_MEM-1:0]            mem_ack,
    input  logic [NUM_MEM*`PIO_NBITS-1:0] mem_rdata
);

    localparam int NB       = `PIO_NBITS;
    localparam int SEL_BITS = $clog2(NUM_MEM);
    localparam int SEL_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam int DIV_W    = (CLK_DIV_RATIO > 2) ? $clog2(CLK_DIV_RATIO) : 1;
    localparam logic [31:0] NUM_MEM_U = NUM_MEM;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DRAIN,
        RESP
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [SEL_W-1:0]   sel_in;
    logic [SEL_W-1:0]   sel_q;
    logic               sel_ok;
    logic               wr_q;
    logic               ack_q;
    logic [NB-1:0]      cap_data;
    logic [NUM_MEM-1:0] ms_dec;
    logic               ack_sel;
    logic [NB-1:0]      rdata_sel;

    // clk_div is registered one count early so it is high exactly while the count is RATIO-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            clk_div <= 1'b0;
        end else begin
            if (div_cnt == DIV_W'(CLK_DIV_RATIO - 1))
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DIV_W'(1);
            clk_div <= (div_cnt == DIV_W'(CLK_DIV_RATIO - 2));
        end
    end

    generate
        if (SEL_BITS > 0) begin : g_sel
            assign sel_in = host_addr[SEL_LSB +: SEL_W];
        end else begin : g_sel_single
            assign sel_in = '0;
        end
    endgenerate

    assign sel_ok = ({{(32-SEL_W){1'b0}}, sel_in} < NUM_MEM_U);

    always_comb begin
        ms_dec    = '0;
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int unsigned i = 0; i < NUM_MEM_U; i++) begin
            if (sel_in == SEL_W'(i))
                ms_dec[i] = 1'b1;
            if (sel_q == SEL_W'(i)) begin
                ack_sel   = mem_ack[i];
                rdata_sel = mem_rdata[i*NB +: NB];
            end
        end
    end

`ifdef PIO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] tcnt;
    logic            timed_out;
    assign timed_out = (tcnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel_q      <= '0;
            wr_q       <= 1'b0;
            ack_q      <= 1'b0;
            cap_data   <= '0;
            host_busy  <= 1'b0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= '0;
            reg_rd     <= 1'b0;
            reg_wr     <= 1'b0;
            reg_ms     <= '0;
            reg_addr   <= '0;
            reg_din    <= '0;
`ifdef PIO_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            reg_rd   <= 1'b0;
            reg_wr   <= 1'b0;
            reg_ms   <= '0;
            host_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_req) begin
                        sel_q     <= sel_in;
                        wr_q      <= host_wr;
                        host_busy <= 1'b1;
                        if (!sel_ok) begin
                            state      <= RESP;
                            host_ack   <= 1'b1;
                            host_err   <= 1'b1;
                            host_rdata <= '0;
                        end else begin
                            state    <= ISSUE;
                            reg_addr <= host_addr;
                            reg_din  <= host_wdata;
                            reg_ms   <= ms_dec;
                            reg_wr   <= host_wr;
                            reg_rd   <= ~host_wr;
                        end
                    end
                end
                ISSUE: begin
                    // sampling the ack here makes an already-high ack look stale
                    ack_q <= ack_sel;
                    state <= WAIT_ACK;
`ifdef PIO_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                WAIT_ACK: begin
                    ack_q <= ack_sel;
                    if (ack_sel && !ack_q) begin
                        cap_data <= wr_q ? '0 : rdata_sel;
                        state    <= DRAIN;
                    end
`ifdef PIO_TIMEOUT_EN
                    tcnt <= tcnt + TO_W'(1);
                    if (timed_out) begin
                        state      <= RESP;
                        host_ack   <= 1'b1;
                        host_err   <= 1'b1;
                        host_rdata <= NB'(32'hDEAD_BEEF);
                    end
`endif
                end
                DRAIN: begin
                    if (!ack_sel) begin
                        state      <= RESP;
                        host_ack   <= 1'b1;
                        host_err   <= 1'b0;
                        host_rdata <= cap_data;
                    end
`ifdef PIO_TIMEOUT_EN
                    tcnt <= tcnt + TO_W'(1);
                    if (timed_out) begin
                        state      <= RESP;
                        host_ack   <= 1'b1;
                        host_err   <= 1'b1;
                        host_rdata <= NB'(32'hDEAD_BEEF);
                    end
`endif
                end
                RESP: begin
                    state     <= IDLE;
                    host_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    host_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
